// File: rtl/ct_f_spsram_512x59_ctrl.sv
// ============================================================================
// Module   : ct_f_spsram_512x59_ctrl
// Desc     : Read/write arbiter, 2-entry write buffer with read forwarding,
//            and post-reset zero-clear for the 512x59 single-port SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_f_spsram_512x59_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 59,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rd_req_vld,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_rdy,
  output logic                  rd_resp_vld,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  input  logic                  wr_req_vld,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  output logic                  wr_req_rdy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int c_cnt_w = $clog2(WBUF_DEPTH + 1);
  localparam int c_idx_w = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_init_cnt;
  logic [ADDR_WIDTH-1:0] r_buf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_buf_data [WBUF_DEPTH];
  logic [c_cnt_w-1:0]    r_buf_cnt;
  logic                  r_resp_vld;
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  logic                  w_run;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_req_rdy;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_drain;
  logic [ADDR_WIDTH:0]   w_init_cnt_nxt;
  logic [c_idx_w-1:0]    w_push_idx;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_run          = (r_state == ST_RUN);
  assign w_full         = (r_buf_cnt == c_cnt_w'(WBUF_DEPTH));
  assign w_empty        = (r_buf_cnt == '0);
  assign w_req_rdy      = w_run & ~w_full;
  assign w_rd_fire      = rd_req_vld & w_req_rdy;
  assign w_wr_fire      = wr_req_vld & w_req_rdy;
  // A full buffer steals the slot; otherwise reads win and the head waits.
  assign w_drain        = w_run & (w_full | (~w_rd_fire & ~w_empty));
  assign w_init_cnt_nxt = r_init_cnt + 1'b1;
  assign w_push_idx     = c_idx_w'(r_buf_cnt - c_cnt_w'(w_drain));

  assign rd_req_rdy   = w_req_rdy;
  assign wr_req_rdy   = w_req_rdy;
  assign init_done    = w_run;
  assign rd_resp_vld  = r_resp_vld;
  assign rd_resp_data = r_resp_vld ? (r_fwd_hit ? r_fwd_data : sram_q) : '0;

  // Youngest valid matching entry wins, so later indices override earlier ones.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((c_cnt_w'(i) < r_buf_cnt) && (r_buf_addr[i] == rd_req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_buf_data[i];
      end
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (r_state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_init_cnt[ADDR_WIDTH-1:0];
    end else if (w_drain) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_buf_addr[0];
      sram_d    = r_buf_data[0];
    end else if (w_rd_fire) begin
      sram_cen  = 1'b0;
      sram_a    = rd_req_addr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_PRE;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        ST_PRE: begin
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
        end
        ST_INIT: begin
          r_init_cnt <= w_init_cnt_nxt;
          if (w_init_cnt_nxt[ADDR_WIDTH]) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_PRE;
        end
      endcase
    end
  end

  // Head is always index 0; a drain shifts entries down, a push lands after
  // the last surviving entry, so drain+push in one cycle keeps the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_buf_cnt <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
          r_buf_addr[i] <= r_buf_addr[i+1];
          r_buf_data[i] <= r_buf_data[i+1];
        end
      end
      if (w_wr_fire) begin
        r_buf_addr[w_push_idx] <= wr_req_addr;
        r_buf_data[w_push_idx] <= wr_req_data;
      end
      r_buf_cnt <= r_buf_cnt + c_cnt_w'(w_wr_fire) - c_cnt_w'(w_drain);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_resp_vld <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_resp_vld <= w_rd_fire;
      if (w_rd_fire) begin
        r_fwd_hit  <= w_fwd_hit;
        r_fwd_data <= w_fwd_data;
      end
    end
  end

endmodule

`default_nettype wire
